saw_voice_sequencer: RTL and testbench

SAW_VOICE_SEQUENCER -- requirements
Module: saw_voice_sequencer

---
 rtl/synth_pkg.sv | 24 ++
 rtl/lin_interp.sv | 22 ++
 rtl/saw_voice_sequencer.sv | 176 +++++++++++++++++
 tb/tb_saw_voice_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and widths for the saw-voice synthesis datapath.
package synth_pkg;

  localparam int PHASE_W = 24;
  localparam int ADDR_W  = 12;
  localparam int SAMP_W  = 16;

  typedef logic signed [SAMP_W-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPT,
    CALC,
    DONE
  } state_e;

  // Table address is the integer part of the phase accumulator.
  function automatic logic [ADDR_W-1:0] phase_addr(input logic [PHASE_W-1:0] phase);
    return phase[PHASE_W-1 -: ADDR_W];
  endfunction

endpackage

// File: rtl/lin_interp.sv
// Combinational linear interpolation between two adjacent saw-table samples.
module lin_interp
  import synth_pkg::*;
#(
  parameter int FRAC_W = 12
) (
  input  sample_t             a_i,
  input  sample_t             b_i,
  input  logic [FRAC_W-1:0]   frac_i,
  output sample_t             result_o
);

  logic signed [SAMP_W:0]          diff;
  logic signed [SAMP_W+FRAC_W+1:0] prod;

  assign diff = $signed({b_i[SAMP_W-1], b_i}) - $signed({a_i[SAMP_W-1], a_i});
  assign prod = diff * $signed({1'b0, frac_i});

  // Floor shift keeps the step inside [A, B], so truncating the sum to 16 bits never wraps.
  assign result_o = SAMP_W'(a_i + (prod >>> FRAC_W));

endmodule

// File: rtl/saw_voice_sequencer.sv
// Time-multiplexes NUM_VOICES saw oscillators over one shared saw-table ROM,
// one sweep per sampleTick, producing registered interpolated samples per voice.
module saw_voice_sequencer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int ROM_LAT    = 2,
  parameter int FRAC_W     = 12
) (
  input  logic                                  Clk,
  input  logic                                  Reset,
  input  logic                                  sampleTick,
  input  logic [NUM_VOICES-1:0]                 gate,
  input  logic [NUM_VOICES-1:0][PHASE_W-1:0]    phaseInc,
  input  logic [NUM_VOICES-1:0][7:0]            octaveSel,
  input  logic                                  overrunClr,
  output logic                                  romReadEn,
  output logic [ADDR_W-1:0]                     romAddr,
  output logic [7:0]                            romOctave,
  input  sample_t                               romSampA,
  input  sample_t                               romSampB,
  output logic [NUM_VOICES-1:0][SAMP_W-1:0]     voiceOut,
  output logic                                  busy,
  output logic                                  sweepDone,
  output logic                                  overrun
);

  localparam int            VW          = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [VW-1:0] LAST_V      = VW'(NUM_VOICES - 1);
  localparam state_e        AFTER_ISSUE = (ROM_LAT == 1) ? CAPT : WAIT;

  state_e                               state_q;
  logic [VW-1:0]                        v_q;
  logic [NUM_VOICES-1:0][PHASE_W-1:0]   phase_q;
  logic [NUM_VOICES-1:0][SAMP_W-1:0]    voice_q;
  sample_t                              samp_a_q;
  sample_t                              samp_b_q;
  logic [FRAC_W-1:0]                    frac_q;
  logic                                 rd_en_q;
  logic [ADDR_W-1:0]                    addr_q;
  logic [7:0]                           oct_q;
  logic                                 busy_q;
  logic                                 done_q;
  logic                                 overrun_q;

  logic [VW-1:0]                        v_next;
  logic                                 last_v;
  logic [PHASE_W-1:0]                   phase_d;
  logic                                 overrun_d;
  logic                                 enter_issue;
  logic [VW-1:0]                        issue_v;
  sample_t                              interp_y;

  assign v_next  = v_q + 1'b1;
  assign last_v  = (v_q == LAST_V);
  assign phase_d = phase_q[v_q] + phaseInc[v_q];

  // A tick that lands while a sweep is running is dropped; set beats clear.
  assign overrun_d = (sampleTick && (state_q != IDLE)) || (overrun_q && !overrunClr);

  lin_interp #(
    .FRAC_W (FRAC_W)
  ) u_interp (
    .a_i      (samp_a_q),
    .b_i      (samp_b_q),
    .frac_i   (frac_q),
    .result_o (interp_y)
  );

  // The ROM request for a voice is registered on the edge that enters ISSUE,
  // so address and readEn are stable for the whole ISSUE cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    enter_issue = 1'b0;
    issue_v     = v_next;
    case (state_q)
      IDLE: begin
        enter_issue = sampleTick;
        issue_v     = '0;
      end
      ISSUE:   enter_issue = !rd_en_q && !last_v;
      CALC:    enter_issue = !last_v;
      default: enter_issue = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      v_q       <= '0;
      // NOTE: per-voice phase and output live in flops, not RAM, so they reset like any other state.
      phase_q   <= '0;
      voice_q   <= '0;
      samp_a_q  <= '0;
      samp_b_q  <= '0;
      frac_q    <= '0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      oct_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads the pre-edge value of each register.
      overrun_q <= overrun_d;
      done_q    <= 1'b0;

      if (enter_issue) begin
        rd_en_q <= gate[issue_v];
        if (gate[issue_v]) begin
          addr_q <= phase_addr(phase_q[issue_v]);
          oct_q  <= octaveSel[issue_v];
        end
      end else begin
        rd_en_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (sampleTick) begin
            state_q <= ISSUE;
            v_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (rd_en_q) begin
            state_q <= AFTER_ISSUE;
          end else begin
            voice_q[v_q] <= '0;
            phase_q[v_q] <= '0;
            if (last_v) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              v_q <= v_next;
            end
          end
        end
        WAIT: state_q <= CAPT;
        CAPT: begin
          samp_a_q <= romSampA;
          samp_b_q <= romSampB;
          frac_q   <= phase_q[v_q][FRAC_W-1:0];
          state_q  <= CALC;
        end
        CALC: begin
          voice_q[v_q] <= interp_y;
          phase_q[v_q] <= phase_d;
          if (last_v) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            v_q     <= v_next;
            state_q <= ISSUE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          v_q     <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign romReadEn = rd_en_q;
  assign romAddr   = addr_q;
  assign romOctave = oct_q;
  assign voiceOut  = voice_q;
  assign busy      = busy_q;
  assign sweepDone = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_saw_voice_sequencer.sv
// Directed bench for saw_voice_sequencer: ROM responder model plus a scoreboard
// of expected ROM reads and per-voice outputs built from an independent phase model.
module tb_saw_voice_sequencer;

  logic              Clk;
  logic              Reset;
  logic              sampleTick;
  logic [3:0]        gate;
  logic [3:0][23:0]  phaseInc;
  logic [3:0][7:0]   octaveSel;
  logic              overrunClr;
  logic              romReadEn;
  logic [11:0]       romAddr;
  logic [7:0]        romOctave;
  logic [15:0]       romSampA;
  logic [15:0]       romSampB;
  logic [3:0][15:0]  voiceOut;
  logic              busy;
  logic              sweepDone;
  logic              overrun;

  saw_voice_sequencer #(
    .NUM_VOICES (4),
    .ROM_LAT    (2),
    .FRAC_W     (12)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .sampleTick (sampleTick),
    .gate       (gate),
    .phaseInc   (phaseInc),
    .octaveSel  (octaveSel),
    .overrunClr (overrunClr),
    .romReadEn  (romReadEn),
    .romAddr    (romAddr),
    .romOctave  (romOctave),
    .romSampA   (romSampA),
    .romSampB   (romSampB),
    .voiceOut   (voiceOut),
    .busy       (busy),
    .sweepDone  (sweepDone),
    .overrun    (overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int rom_mode = 0;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [7:0]  oct;
  } rd_t;

  rd_t         rd_q[$];
  logic [15:0] out_q[$];
  logic [23:0] mphase[4];

  function automatic logic [15:0] rom_a(input logic [11:0] a);
    if (rom_mode != 0) return 16'h7FFF;
    return {a, 4'h0};
  endfunction

  function automatic logic [15:0] rom_b(input logic [11:0] a);
    logic [11:0] nxt;
    if (rom_mode != 0) return 16'h8000;
    nxt = a + 12'd1;
    return {nxt, 4'h0};
  endfunction

  // Two-stage table: address registered on the readEn edge, data one edge later.
  logic [11:0] rom_s1 = 12'd0;
  always @(posedge Clk) begin
    if (romReadEn) rom_s1 <= romAddr;
    romSampA <= rom_a(rom_s1);
    romSampB <= rom_b(rom_s1);
  end

  function automatic logic [15:0] model_interp(input logic [15:0] a, input logic [15:0] b,
                                               input logic [11:0] f);
    int sa, sb, d, q;
    sa = int'($signed(a));
    sb = int'($signed(b));
    d  = (sb - sa) * int'(f);
    if (d >= 0) q = d / 4096;
    else        q = -((-d + 4095) / 4096);
    return 16'(sa + q);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet_outputs(input string where);
    check({where, "_readen"},  romReadEn, 0);
    check({where, "_addr"},    romAddr, 0);
    check({where, "_octave"},  romOctave, 0);
    check({where, "_busy"},    busy, 0);
    check({where, "_done"},    sweepDone, 0);
    check({where, "_overrun"}, overrun, 0);
    for (int v = 0; v < 4; v++) check({where, "_voice"}, voiceOut[v], 0);
  endtask

  task automatic model_reset();
    for (int v = 0; v < 4; v++) mphase[v] = 24'd0;
    rd_q.delete();
    out_q.delete();
  endtask

  // Starts one sweep from the current negedge; optional extra tick / clear pulses at given cycles.
  task automatic run_sweep(input logic [3:0] g, input int tick_at, input int clr_at);
    int          c;
    int          exp_done;
    bit          seen;
    rd_t         e;
    logic [11:0] ad;
    logic [11:0] fr;
    c = 1;
    for (int v = 0; v < 4; v++) begin
      if (g[v]) begin
        ad = mphase[v][23:12];
        fr = mphase[v][11:0];
        rd_q.push_back('{cyc: c, addr: ad, oct: octaveSel[v]});
        out_q.push_back(model_interp(rom_a(ad), rom_b(ad), fr));
        mphase[v] = mphase[v] + phaseInc[v];
        c += 4;
      end else begin
        out_q.push_back(16'h0000);
        mphase[v] = 24'd0;
        c += 1;
      end
    end
    exp_done   = c;
    gate       = g;
    sampleTick = 1'b1;
    seen       = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge Clk);
      if (romReadEn) begin
        if (rd_q.size() == 0) begin
          check("unexpected_read", k, 0);
        end else begin
          e = rd_q.pop_front();
          check("read_cycle", k, e.cyc);
          check("read_addr", romAddr, e.addr);
          check("read_octave", romOctave, e.oct);
        end
      end
      check("busy_in_sweep", busy, 1);
      sampleTick = (k == tick_at);
      overrunClr = (k == clr_at);
      if (sweepDone) begin
        check("done_cycle", k, exp_done);
        seen = 1'b1;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    @(negedge Clk);
    sampleTick = 1'b0;
    overrunClr = 1'b0;
    check("busy_after_sweep", busy, 0);
    check("done_after_sweep", sweepDone, 0);
    check("missing_reads", rd_q.size(), 0);
    rd_q.delete();
    for (int v = 0; v < 4; v++) check("voice_out", voiceOut[v], out_q.pop_front());
  endtask

  initial begin
    Reset      = 1'b1;
    sampleTick = 1'b0;
    overrunClr = 1'b0;
    gate       = 4'h0;
    phaseInc   = {24'hFFF800, 24'h800000, 24'h123456, 24'h001800};
    octaveSel  = {8'h05, 8'h04, 8'h02, 8'h01};
    model_reset();

    repeat (2) @(negedge Clk);
    check_quiet_outputs("reset");
    Reset = 1'b0;
    @(negedge Clk);

    // Four gated voices: interpolation, phase wrap, table-end address, octave pass-through.
    run_sweep(4'hF, 0, 0);
    check("v0_sweep1", voiceOut[0], 16'd0);
    run_sweep(4'hF, 0, 0);
    check("v0_sweep2", voiceOut[0], 16'd24);
    check("v3_addr_fff", voiceOut[3], 16'hFFF8);

    // Stray tick mid-sweep sets overrun without disturbing timing.
    run_sweep(4'hF, 5, 0);
    check("overrun_set", overrun, 1);
    // Ignored tick in DONE together with clear: set wins.
    run_sweep(4'hF, 17, 17);
    check("overrun_hold", overrun, 1);
    overrunClr = 1'b1;
    @(negedge Clk);
    overrunClr = 1'b0;
    @(negedge Clk);
    check("overrun_clear", overrun, 0);

    // Asynchronous reset in the middle of a sweep.
    gate       = 4'hF;
    sampleTick = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      sampleTick = 1'b0;
    end
    Reset = 1'b1;
    #1;
    check_quiet_outputs("midreset");
    @(negedge Clk);
    check("midreset_busy_next", busy, 0);
    Reset = 1'b0;
    model_reset();
    run_sweep(4'hF, 0, 0);

    // Extreme neighbours 0x7FFF / 0x8000 on a single gated voice.
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    rom_mode    = 1;
    phaseInc[0] = 24'h000400;
    run_sweep(4'b0001, 0, 0);
    check("extreme_frac0", voiceOut[0], 16'h7FFF);
    run_sweep(4'b0001, 0, 0);
    check("extreme_frac400", voiceOut[0], 16'h3FFF);

    // All gates low: no reads, everything zero, short sweep.
    rom_mode = 0;
    run_sweep(4'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
